calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Key-driven control FSM for the calculator top. Debounces the operand-load and operation keys, latches operand A and operand B from in_number, and issues one operation to the arithmetic unit through a start/done handshake. Captures the result or error and drives the value and LED state consumed by the 7-segment display driver. Sits between the board keys and the ALU/display datapath inside top.

Parameters:
IN_WIDTH, 4, operand width (unsigned)
RES_WIDTH, 9, signed result/display width; covers -15..225
LED_WIDTH, 3, status LED width
DEBOUNCE_CYCLES, 1000, consecutive stable cycles before a key level is accepted
TIMEOUT_CYCLES, 64, maximum BUSY cycles before the ALU is declared hung

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
in_number  in  IN_WIDTH  operand switches
k_1  in  1  raw key: load operand A
k_2  in  1  raw key: load operand B
plus_key / substract_key / devide_key / multiply_key  in  1 each  raw operation keys
alu_op  out  2  op_t, held stable while BUSY
alu_a / alu_b  out  IN_WIDTH each  latched operands
alu_start  out  1  one-cycle request pulse
alu_done  in  1  one-cycle completion pulse
alu_result  in  RES_WIDTH  signed result, valid with alu_done
alu_err  in  1  divide by zero, valid with alu_done
disp_value  out  RES_WIDTH  signed value to display
disp_err  out  1  display shows E
led  out  LED_WIDTH  status one-hot

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State: IDLE_A.
  - alu_a, alu_b, alu_op, disp_value: 0.
  - alu_start, disp_err: 0.
  - led: 001.
  - a_valid: 0.
  - Debouncer counters and levels: 0.
- Reset mid-BUSY abandons the operation. A later alu_done is ignored because the state is no longer BUSY.
- Debounce: the level changes only after the raw input differs from the current level for DEBOUNCE_CYCLES consecutive cycles. The counter restarts on any glitch. Press = one-cycle pulse on the rising edge of the level. Raw-to-pulse latency is DEBOUNCE_CYCLES+1 cycles. Releases generate nothing.
- Press arbitration, same cycle: k_1 > k_2 > plus > sub > div > mul. Only the winner acts; other pulses that cycle are dropped.
- FSM (led in brackets):
  - IDLE_A [001]
    - k_1: alu_a<=in_number, disp_value<=in_number, disp_err<=0, a_valid<=1, go HAVE_A.
    - k_2 with a_valid=1: alu_b<=in_number, disp_value<=in_number, disp_err<=0, go HAVE_B.
    - Otherwise ignored.
  - HAVE_A [010]
    - k_1: reload A.
    - k_2: load B, go HAVE_B.
    - Op keys ignored.
  - HAVE_B [100]
    - k_1: reload A, go HAVE_A.
    - k_2: reload B.
    - Op key: alu_op<=op, alu_start=1 for exactly the next cycle, go BUSY.
  - BUSY [100]
    - All key presses ignored.
    - alu_done: if alu_err, disp_err<=1 and disp_value<=0; else disp_value<=alu_result and disp_err<=0. Go IDLE_A.
    - Timer reaching TIMEOUT_CYCLES without done: disp_err<=1, go IDLE_A.
    - alu_done in the same cycle as alu_start is illegal; the earliest accepted done is one cycle after the start pulse.
- alu_a, alu_b and alu_op never change while BUSY.
- alu_done outside BUSY is ignored.
- a_valid persists after a result, so k_2 then op repeats with the retained A.
- led is a registered decode of state and is always one-hot.

Decomposition:
- calc_pkg holds:
  - op_t: OP_ADD=0, OP_SUB=1, OP_DIV=2, OP_MUL=3.
  - state_t: IDLE_A, HAVE_A, HAVE_B, BUSY.
  - LED constants: LED_IDLE=3'b001, LED_A=3'b010, LED_B=3'b100.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw, level, press), instantiated six times.
- Arbitration and FSM stay in calc_sequencer.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4 and a behavioural ALU with 3-cycle latency.
1. Reset, then in_number=5 and k_1 held 10 cycles -> led 001 then 010; alu_a=5; disp_value=5; exactly one load.
2. k_1 with 7, k_2 with 9, plus_key -> alu_start for one cycle with alu_op=OP_ADD, a=7, b=9; led 100 during BUSY; after done disp_value=16, led 001.
3. A=3, B=12, substract -> disp_value=-9 (9'h1F7), disp_err=0; then k_2 with 0 and devide -> alu_err -> disp_err=1, disp_value=0, led 001.
4. Op key in HAVE_A, k_2 in IDLE_A before any k_1, and keys during BUSY -> no state or register change and no alu_start.
5. k_1 and k_2 debounced in the same cycle in HAVE_B -> only A reloads, state HAVE_A. A raw glitch of 3 cycles -> no press.
6. Withhold alu_done for 64 cycles -> disp_err=1, IDLE_A. rst_n=0 during BUSY -> all outputs at reset values next cycle; a stale done is ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control path.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_DIV = 2'd2,
        OP_MUL = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE_A = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2,
        BUSY   = 2'd3
    } state_t;

    localparam logic [2:0] LED_IDLE = 3'b001;
    localparam logic [2:0] LED_A    = 3'b010;
    localparam logic [2:0] LED_B    = 3'b100;

    // Status LED pattern shown for each state; BUSY shares the HAVE_B pattern.
    function automatic logic [2:0] led_of(input state_t s);
        logic [2:0] l;
        case (s)
            IDLE_A:  l = LED_IDLE;
            HAVE_A:  l = LED_A;
            default: l = LED_B;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one raw key: the level follows the raw input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles; press is a one-cycle
// pulse on each rising edge of the accepted level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          press_q, press_d;

    // Count consecutive disagreeing samples; any agreement restarts the count.
    always_comb begin
        level_d     = level_q;
        cnt_d       = '0;
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
        if (raw != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/calc_sequencer.sv
// Key-driven control FSM for the calculator: loads operands, issues one ALU
// operation via start/done, and drives the display value and status LEDs.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int IN_WIDTH        = 4,
    parameter int RES_WIDTH       = 9,
    parameter int LED_WIDTH       = 3,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_number,
    input  logic                 k_1,
    input  logic                 k_2,
    input  logic                 plus_key,
    input  logic                 substract_key,
    input  logic                 devide_key,
    input  logic                 multiply_key,
    output logic [1:0]           alu_op,
    output logic [IN_WIDTH-1:0]  alu_a,
    output logic [IN_WIDTH-1:0]  alu_b,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [RES_WIDTH-1:0] alu_result,
    input  logic                 alu_err,
    output logic [RES_WIDTH-1:0] disp_value,
    output logic                 disp_err,
    output logic [LED_WIDTH-1:0] led
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [5:0] raw_keys;
    logic [5:0] key_press;
    logic [5:0] key_level_unused;

    assign raw_keys = {multiply_key, devide_key, substract_key, plus_key, k_2, k_1};

    for (genvar i = 0; i < 6; i++) begin : g_deb
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_keys[i]),
            .level (key_level_unused[i]),
            .press (key_press[i])
        );
    end

    logic win_k1, win_k2, win_op;
    op_t  win_code;

    // Fixed-priority arbitration of same-cycle presses; losers are dropped.
    always_comb begin
        win_k1   = 1'b0;
        win_k2   = 1'b0;
        win_op   = 1'b0;
        win_code = OP_ADD;
        if (key_press[0]) begin
            win_k1 = 1'b1;
        end else if (key_press[1]) begin
            win_k2 = 1'b1;
        end else if (key_press[2]) begin
            win_op = 1'b1;
        end else if (key_press[3]) begin
            win_op   = 1'b1;
            win_code = OP_SUB;
        end else if (key_press[4]) begin
            win_op   = 1'b1;
            win_code = OP_DIV;
        end else if (key_press[5]) begin
            win_op   = 1'b1;
            win_code = OP_MUL;
        end
    end

    state_t               state_q, state_d;
    op_t                  alu_op_q, alu_op_d;
    logic [IN_WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic                 alu_start_q, alu_start_d;
    logic [RES_WIDTH-1:0] disp_value_q, disp_value_d;
    logic                 disp_err_q, disp_err_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 a_valid_q, a_valid_d;
    logic [TW-1:0]        timer_q, timer_d;

    // Next-state and register updates; done on the start cycle is not accepted.
    always_comb begin
        state_d      = state_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_start_d  = 1'b0;
        disp_value_d = disp_value_q;
        disp_err_d   = disp_err_q;
        a_valid_d    = a_valid_q;
        timer_d      = timer_q;
        case (state_q)
            IDLE_A, HAVE_A, HAVE_B: begin
                if (win_k1) begin
                    alu_a_d      = in_number;
                    disp_value_d = RES_WIDTH'(in_number);
                    disp_err_d   = 1'b0;
                    a_valid_d    = 1'b1;
                    state_d      = HAVE_A;
                end else if (win_k2 && (state_q != IDLE_A || a_valid_q)) begin
                    alu_b_d      = in_number;
                    disp_value_d = RES_WIDTH'(in_number);
                    disp_err_d   = 1'b0;
                    state_d      = HAVE_B;
                end else if (win_op && state_q == HAVE_B) begin
                    alu_op_d    = win_code;
                    alu_start_d = 1'b1;
                    timer_d     = TW'(TIMEOUT_CYCLES - 1);
                    state_d     = BUSY;
                end
            end
            default: begin
                if (alu_done && !alu_start_q) begin
                    disp_err_d   = alu_err;
                    disp_value_d = alu_err ? '0 : alu_result;
                    state_d      = IDLE_A;
                end else if (timer_q == '0) begin
                    disp_err_d = 1'b1;
                    state_d    = IDLE_A;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
        endcase
        led_d = LED_WIDTH'(led_of(state_d));
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE_A;
            alu_op_q     <= OP_ADD;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_start_q  <= 1'b0;
            disp_value_q <= '0;
            disp_err_q   <= 1'b0;
            led_q        <= LED_WIDTH'(LED_IDLE);
            a_valid_q    <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_start_q  <= alu_start_d;
            disp_value_q <= disp_value_d;
            disp_err_q   <= disp_err_d;
            led_q        <= led_d;
            a_valid_q    <= a_valid_d;
            timer_q      <= timer_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_start  = alu_start_q;
    assign disp_value = disp_value_q;
    assign disp_err   = disp_err_q;
    assign led        = led_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a 3-cycle behavioural ALU.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_number = 4'd0;
    logic [5:0] keys = 6'd0;   // {mul, div, sub, plus, k_2, k_1}
    logic [1:0] alu_op;
    logic [3:0] alu_a, alu_b;
    logic       alu_start;
    logic       alu_done_m = 1'b0, inj_done = 1'b0, alu_err_m = 1'b0;
    logic [8:0] alu_res_m = 9'd0, inj_res = 9'd0;
    logic [8:0] disp_value;
    logic       disp_err;
    logic [2:0] led;
    logic       alu_en = 1'b1;
    logic [1:0] m_op;
    logic [3:0] m_a, m_b;
    int         checks = 0, failures = 0, start_cnt = 0, s0;

    calc_sequencer #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_number(in_number),
        .k_1(keys[0]), .k_2(keys[1]), .plus_key(keys[2]),
        .substract_key(keys[3]), .devide_key(keys[4]), .multiply_key(keys[5]),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done_m | inj_done), .alu_result(alu_res_m | inj_res),
        .alu_err(alu_err_m), .disp_value(disp_value), .disp_err(disp_err), .led(led)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) if (alu_start) start_cnt++;

    // Behavioural ALU: done pulse three cycles after the start pulse.
    initial forever begin
        @(posedge clk);
        if (alu_start && alu_en) begin
            m_op = alu_op; m_a = alu_a; m_b = alu_b;
            repeat (2) @(posedge clk);
            #1;
            alu_done_m = 1'b1;
            case (m_op)
                2'd0: alu_res_m = 9'({5'd0, m_a}) + 9'({5'd0, m_b});
                2'd1: alu_res_m = 9'({5'd0, m_a}) - 9'({5'd0, m_b});
                2'd2: begin
                    if (m_b == 4'd0) alu_err_m = 1'b1;
                    else alu_res_m = 9'(m_a / m_b);
                end
                default: alu_res_m = 9'(m_a * m_b);
            endcase
            @(posedge clk);
            #1;
            alu_done_m = 1'b0; alu_res_m = 9'd0; alu_err_m = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        keys[k] = 1'b1;
        repeat (8) tick();
        keys[k] = 1'b0;
        repeat (7) tick();
    endtask

    task automatic wait_start();
        int n = 0;
        while (!alu_start && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", 16'(alu_start), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_led", 16'(led), 16'h1);
        chk("rst_a", 16'(alu_a), 16'h0);
        chk("rst_b", 16'(alu_b), 16'h0);
        chk("rst_op", 16'(alu_op), 16'h0);
        chk("rst_disp", 16'(disp_value), 16'h0);
        chk("rst_err", 16'(disp_err), 16'h0);
        chk("rst_start", 16'(alu_start), 16'h0);
        rst_n = 1'b1;
        tick();

        // k_2 before any k_1 is ignored
        in_number = 4'd7;
        press(1);
        chk("k2_noa_led", 16'(led), 16'h1);
        chk("k2_noa_b", 16'(alu_b), 16'h0);

        // Test 1: k_1 held 10 cycles loads A exactly once
        in_number = 4'd5;
        keys[0] = 1'b1;
        repeat (3) tick();
        chk("t1_led_early", 16'(led), 16'h1);
        repeat (7) tick();
        chk("t1_led", 16'(led), 16'h2);
        chk("t1_a", 16'(alu_a), 16'h5);
        chk("t1_disp", 16'(disp_value), 16'h5);
        in_number = 4'd6;
        repeat (2) tick();
        keys[0] = 1'b0;
        repeat (7) tick();
        chk("t1_one_load", 16'(alu_a), 16'h5);

        // op key in HAVE_A is ignored
        s0 = start_cnt;
        press(2);
        chk("opA_led", 16'(led), 16'h2);
        chk("opA_nostart", 16'(start_cnt - s0), 16'd0);

        // Test 2: 7 + 9
        in_number = 4'd7; press(0);
        in_number = 4'd9; press(1);
        chk("t2_haveb_led", 16'(led), 16'h4);
        s0 = start_cnt;
        keys[2] = 1'b1;
        wait_start();
        chk("t2_op", 16'(alu_op), 16'h0);
        chk("t2_a", 16'(alu_a), 16'h7);
        chk("t2_b", 16'(alu_b), 16'h9);
        chk("t2_busy_led", 16'(led), 16'h4);
        tick();
        chk("t2_start_width", 16'(alu_start), 16'h0);
        keys[2] = 1'b0;
        repeat (5) tick();
        chk("t2_disp", 16'(disp_value), 16'h010);
        chk("t2_err", 16'(disp_err), 16'h0);
        chk("t2_led", 16'(led), 16'h1);
        chk("t2_nstart", 16'(start_cnt - s0), 16'd1);
        repeat (6) tick();

        // Test 3: 3 - 12, then divide by zero with retained A
        in_number = 4'd3; press(0);
        in_number = 4'd12; press(1);
        keys[3] = 1'b1;
        wait_start();
        chk("t3_op", 16'(alu_op), 16'h1);
        keys[3] = 1'b0;
        repeat (5) tick();
        chk("t3_disp", 16'(disp_value), 16'h1F7);
        chk("t3_err", 16'(disp_err), 16'h0);
        in_number = 4'd0; press(1);
        chk("t3_reb_led", 16'(led), 16'h4);
        keys[4] = 1'b1;
        wait_start();
        chk("t3_divop", 16'(alu_op), 16'h2);
        keys[4] = 1'b0;
        repeat (5) tick();
        chk("t3_div_err", 16'(disp_err), 16'h1);
        chk("t3_div_disp", 16'(disp_value), 16'h0);
        chk("t3_div_led", 16'(led), 16'h1);
        repeat (6) tick();

        // Test 5: k_1 and k_2 together in HAVE_B, then a short glitch
        in_number = 4'd4; press(0);
        in_number = 4'd6; press(1);
        in_number = 4'd8;
        keys[1:0] = 2'b11;
        repeat (8) tick();
        keys[1:0] = 2'b00;
        repeat (7) tick();
        chk("t5_led", 16'(led), 16'h2);
        chk("t5_a", 16'(alu_a), 16'h8);
        chk("t5_b", 16'(alu_b), 16'h6);
        in_number = 4'd11;
        keys[1] = 1'b1;
        repeat (3) tick();
        keys[1] = 1'b0;
        repeat (8) tick();
        chk("t5_glitch_led", 16'(led), 16'h2);
        chk("t5_glitch_b", 16'(alu_b), 16'h6);

        // Test 6: timeout, with a k_1 press during BUSY
        in_number = 4'd5; press(1);
        alu_en = 1'b0;
        keys[2] = 1'b1;
        wait_start();
        keys[2] = 1'b0;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (i == 10) begin in_number = 4'd15; keys[0] = 1'b1; end
            if (i == 30) keys[0] = 1'b0;
        end
        chk("t6_busy63_led", 16'(led), 16'h4);
        chk("t6_busy_err", 16'(disp_err), 16'h0);
        tick();
        chk("t6_to_led", 16'(led), 16'h1);
        chk("t6_to_err", 16'(disp_err), 16'h1);
        chk("t6_a_held", 16'(alu_a), 16'h8);
        repeat (6) tick();

        // Reset during BUSY, then a stale done
        in_number = 4'd2; press(1);
        keys[5] = 1'b1;
        wait_start();
        chk("rb_op", 16'(alu_op), 16'h3);
        keys[5] = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("rb_led", 16'(led), 16'h1);
        chk("rb_a", 16'(alu_a), 16'h0);
        chk("rb_b", 16'(alu_b), 16'h0);
        chk("rb_op0", 16'(alu_op), 16'h0);
        chk("rb_disp", 16'(disp_value), 16'h0);
        chk("rb_err", 16'(disp_err), 16'h0);
        chk("rb_start", 16'(alu_start), 16'h0);
        rst_n = 1'b1;
        tick();
        inj_done = 1'b1; inj_res = 9'h055;
        tick();
        inj_done = 1'b0; inj_res = 9'h000;
        tick();
        chk("stale_disp", 16'(disp_value), 16'h0);
        chk("stale_led", 16'(led), 16'h1);
        in_number = 4'd9; press(1);
        chk("rb_aval_led", 16'(led), 16'h1);
        chk("rb_aval_b", 16'(alu_b), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
